// File: rtl/pe_os.sv
`default_nettype none
// ============================================================================
//  Module   : pe_os
//  Purpose  : Output-stationary systolic PE: forwards A/B operands, MACs on
//             matching k tags, and injects/forwards accumulator drain beats.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_os #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 8,
   parameter int SIGNED = 1,
   parameter int SAT    = 0
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              top_data_valid_i,
   input  logic [CNT_W-1:0]  top_data_cnt_i,
   input  logic [DATA_W-1:0] top_data_i,
   input  logic              top_storec_valid_i,
   input  logic              top_c_valid_i,
   input  logic [ACC_W-1:0]  top_c_i,

   input  logic              left_data_valid_i,
   input  logic [CNT_W-1:0]  left_data_cnt_i,
   input  logic              left_data_type_i,
   input  logic [DATA_W-1:0] left_data_i,

   output logic              bot_data_valid_o,
   output logic [CNT_W-1:0]  bot_data_cnt_o,
   output logic [DATA_W-1:0] bot_data_o,

   output logic              right_data_valid_o,
   output logic [CNT_W-1:0]  right_data_cnt_o,
   output logic              right_data_type_o,
   output logic [DATA_W-1:0] right_data_o,

   output logic              bot_storec_valid_o,
   output logic              bot_c_valid_o,
   output logic [ACC_W-1:0]  bot_c_o,

   output logic              err_o
);

   localparam int PROD_W = 2 * DATA_W;

   localparam logic [ACC_W-1:0] c_smax = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] c_smin = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [ACC_W-1:0] c_umax = {ACC_W{1'b1}};

   logic              w_both_valid;
   logic              w_fire;
   logic              w_mismatch;
   logic              w_collide;

   logic [PROD_W-1:0] w_a_x;
   logic [PROD_W-1:0] w_b_x;
   logic [PROD_W-1:0] w_prod_n;
   logic [ACC_W-1:0]  w_prod;
   logic [ACC_W:0]    w_sum_x;
   logic [ACC_W-1:0]  w_sum;
   logic              w_ovf_pos;
   logic              w_ovf_neg;
   logic [ACC_W-1:0]  w_sat_sum;
   logic [ACC_W-1:0]  w_mac;
   logic [ACC_W-1:0]  w_acc_next;

   logic [ACC_W-1:0]  r_acc;
   logic              r_fwd_v;
   logic [ACC_W-1:0]  r_fwd_c;

   assign w_both_valid = left_data_valid_i & top_data_valid_i;
   assign w_fire       = w_both_valid & (left_data_cnt_i == top_data_cnt_i);
   assign w_mismatch   = w_both_valid & (left_data_cnt_i != top_data_cnt_i);
   // An upstream beat sitting in the first drain stage would land on bot_c_o
   // in the same cycle as our own inject.
   assign w_collide    = r_fwd_v & top_storec_valid_i;

   // Operands are widened to the product width so a single multiplier serves
   // both signed and unsigned modes; the low PROD_W bits are exact either way.
   always_comb begin
      w_a_x = '0;
      w_b_x = '0;
      w_a_x[DATA_W-1:0] = left_data_i;
      w_b_x[DATA_W-1:0] = top_data_i;
      if (SIGNED != 0) begin
         for (int i = DATA_W; i < PROD_W; i++) begin
            w_a_x[i] = left_data_i[DATA_W-1];
            w_b_x[i] = top_data_i[DATA_W-1];
         end
      end
   end

   assign w_prod_n = w_a_x * w_b_x;

   always_comb begin
      w_prod = '0;
      w_prod[PROD_W-1:0] = w_prod_n;
      if (SIGNED != 0) begin
         for (int i = PROD_W; i < ACC_W; i++) begin
            w_prod[i] = w_prod_n[PROD_W-1];
         end
      end
   end

   assign w_sum_x = {1'b0, r_acc} + {1'b0, w_prod};
   assign w_sum   = w_sum_x[ACC_W-1:0];

   always_comb begin
      w_ovf_pos = 1'b0;
      w_ovf_neg = 1'b0;
      if (SIGNED != 0) begin
         w_ovf_pos = ~r_acc[ACC_W-1] & ~w_prod[ACC_W-1] &  w_sum[ACC_W-1];
         w_ovf_neg =  r_acc[ACC_W-1] &  w_prod[ACC_W-1] & ~w_sum[ACC_W-1];
      end else begin
         w_ovf_pos = w_sum_x[ACC_W];
      end
   end

   always_comb begin
      w_sat_sum = w_sum;
      if (SAT != 0) begin
         if (w_ovf_pos) begin
            w_sat_sum = (SIGNED != 0) ? c_smax : c_umax;
         end else if (w_ovf_neg) begin
            w_sat_sum = c_smin;
         end
      end
   end

   assign w_mac      = left_data_type_i ? w_prod : w_sat_sum;
   assign w_acc_next = w_fire ? w_mac : r_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bot_data_valid_o   <= 1'b0;
         bot_data_cnt_o     <= '0;
         bot_data_o         <= '0;
         right_data_valid_o <= 1'b0;
         right_data_cnt_o   <= '0;
         right_data_type_o  <= 1'b0;
         right_data_o       <= '0;
         bot_storec_valid_o <= 1'b0;
         bot_c_valid_o      <= 1'b0;
         bot_c_o            <= '0;
         err_o              <= 1'b0;
         r_acc              <= '0;
         r_fwd_v            <= 1'b0;
         r_fwd_c            <= '0;
      end else begin
         bot_data_valid_o   <= top_data_valid_i;
         bot_data_cnt_o     <= top_data_cnt_i;
         bot_data_o         <= top_data_i;
         right_data_valid_o <= left_data_valid_i;
         right_data_cnt_o   <= left_data_cnt_i;
         right_data_type_o  <= left_data_type_i;
         right_data_o       <= left_data_i;
         bot_storec_valid_o <= top_storec_valid_i;

         r_fwd_v <= top_c_valid_i;
         r_fwd_c <= top_c_i;

         // Own result takes the output slot; a colliding upstream beat is lost.
         if (top_storec_valid_i) begin
            bot_c_valid_o <= 1'b1;
            bot_c_o       <= w_acc_next;
            r_acc         <= '0;
         end else begin
            bot_c_valid_o <= r_fwd_v;
            bot_c_o       <= r_fwd_c;
            r_acc         <= w_acc_next;
         end

         if (w_mismatch || w_collide) begin
            err_o <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pe_os.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_os
//  Purpose  : Self-checking bench for pe_os: vector table with drain
//             scoreboard, plus saturation, column-drain and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_os;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc = cyc + 1;

   // ---------------- main DUT (defaults) ----------------
   logic        t_valid, t_st, t_cv, l_valid, l_type;
   logic [7:0]  t_cnt, t_data, l_cnt, l_data;
   logic [31:0] t_c;
   logic        bd_valid, rd_valid, rd_type, b_st, bc_valid, err;
   logic [7:0]  bd_cnt, bd_data, rd_cnt, rd_data;
   logic [31:0] bc;

   pe_os u_dut (
      .clk(clk), .rst_n(rst_n),
      .top_data_valid_i(t_valid), .top_data_cnt_i(t_cnt), .top_data_i(t_data),
      .top_storec_valid_i(t_st), .top_c_valid_i(t_cv), .top_c_i(t_c),
      .left_data_valid_i(l_valid), .left_data_cnt_i(l_cnt),
      .left_data_type_i(l_type), .left_data_i(l_data),
      .bot_data_valid_o(bd_valid), .bot_data_cnt_o(bd_cnt), .bot_data_o(bd_data),
      .right_data_valid_o(rd_valid), .right_data_cnt_o(rd_cnt),
      .right_data_type_o(rd_type), .right_data_o(rd_data),
      .bot_storec_valid_o(b_st), .bot_c_valid_o(bc_valid), .bot_c_o(bc),
      .err_o(err)
   );

   // ---------------- 16-bit accumulator pair: [0] saturating, [1] wrapping ----
   logic       s_lv, s_tv, s_type, s_st;
   logic [7:0] s_cnt, s_a, s_b;
   logic       sa_bdv[2], sa_rv[2], sa_rt[2], sa_bst[2], sa_cv[2], sa_err[2];
   logic [7:0] sa_bdc[2], sa_bd[2], sa_rc[2], sa_rd[2];
   logic [15:0] sa_c[2];

   for (genvar g = 0; g < 2; g++) begin : g_sat
      pe_os #(.DATA_W(8), .ACC_W(16), .CNT_W(8), .SIGNED(1), .SAT(1 - g)) u_pe (
         .clk(clk), .rst_n(rst_n),
         .top_data_valid_i(s_tv), .top_data_cnt_i(s_cnt), .top_data_i(s_b),
         .top_storec_valid_i(s_st), .top_c_valid_i(1'b0), .top_c_i(16'h0000),
         .left_data_valid_i(s_lv), .left_data_cnt_i(s_cnt),
         .left_data_type_i(s_type), .left_data_i(s_a),
         .bot_data_valid_o(sa_bdv[g]), .bot_data_cnt_o(sa_bdc[g]), .bot_data_o(sa_bd[g]),
         .right_data_valid_o(sa_rv[g]), .right_data_cnt_o(sa_rc[g]),
         .right_data_type_o(sa_rt[g]), .right_data_o(sa_rd[g]),
         .bot_storec_valid_o(sa_bst[g]), .bot_c_valid_o(sa_cv[g]), .bot_c_o(sa_c[g]),
         .err_o(sa_err[g])
      );
   end

   // ---------------- 3-PE column ----------------
   logic        col_tv, col_st;
   logic [7:0]  col_tc, col_td;
   logic        cl_v[3], cl_t[3];
   logic [7:0]  cl_c[3], cl_d[3];
   logic        c_bdv[3], c_rv[3], c_rt[3], c_bst[3], c_bcv[3], c_err[3];
   logic [7:0]  c_bdc[3], c_bd[3], c_rc[3], c_rd[3];
   logic [31:0] c_bc[3];

   pe_os u_c0 (
      .clk(clk), .rst_n(rst_n),
      .top_data_valid_i(col_tv), .top_data_cnt_i(col_tc), .top_data_i(col_td),
      .top_storec_valid_i(col_st), .top_c_valid_i(1'b0), .top_c_i(32'h0),
      .left_data_valid_i(cl_v[0]), .left_data_cnt_i(cl_c[0]),
      .left_data_type_i(cl_t[0]), .left_data_i(cl_d[0]),
      .bot_data_valid_o(c_bdv[0]), .bot_data_cnt_o(c_bdc[0]), .bot_data_o(c_bd[0]),
      .right_data_valid_o(c_rv[0]), .right_data_cnt_o(c_rc[0]),
      .right_data_type_o(c_rt[0]), .right_data_o(c_rd[0]),
      .bot_storec_valid_o(c_bst[0]), .bot_c_valid_o(c_bcv[0]), .bot_c_o(c_bc[0]),
      .err_o(c_err[0])
   );

   pe_os u_c1 (
      .clk(clk), .rst_n(rst_n),
      .top_data_valid_i(c_bdv[0]), .top_data_cnt_i(c_bdc[0]), .top_data_i(c_bd[0]),
      .top_storec_valid_i(c_bst[0]), .top_c_valid_i(c_bcv[0]), .top_c_i(c_bc[0]),
      .left_data_valid_i(cl_v[1]), .left_data_cnt_i(cl_c[1]),
      .left_data_type_i(cl_t[1]), .left_data_i(cl_d[1]),
      .bot_data_valid_o(c_bdv[1]), .bot_data_cnt_o(c_bdc[1]), .bot_data_o(c_bd[1]),
      .right_data_valid_o(c_rv[1]), .right_data_cnt_o(c_rc[1]),
      .right_data_type_o(c_rt[1]), .right_data_o(c_rd[1]),
      .bot_storec_valid_o(c_bst[1]), .bot_c_valid_o(c_bcv[1]), .bot_c_o(c_bc[1]),
      .err_o(c_err[1])
   );

   pe_os u_c2 (
      .clk(clk), .rst_n(rst_n),
      .top_data_valid_i(c_bdv[1]), .top_data_cnt_i(c_bdc[1]), .top_data_i(c_bd[1]),
      .top_storec_valid_i(c_bst[1]), .top_c_valid_i(c_bcv[1]), .top_c_i(c_bc[1]),
      .left_data_valid_i(cl_v[2]), .left_data_cnt_i(cl_c[2]),
      .left_data_type_i(cl_t[2]), .left_data_i(cl_d[2]),
      .bot_data_valid_o(c_bdv[2]), .bot_data_cnt_o(c_bdc[2]), .bot_data_o(c_bd[2]),
      .right_data_valid_o(c_rv[2]), .right_data_cnt_o(c_rc[2]),
      .right_data_type_o(c_rt[2]), .right_data_o(c_rd[2]),
      .bot_storec_valid_o(c_bst[2]), .bot_c_valid_o(c_bcv[2]), .bot_c_o(c_bc[2]),
      .err_o(c_err[2])
   );

   // ---------------- vectors and scoreboard ----------------
   typedef struct {
      logic        lv, tv, typ, st, cv, c_exp, exp_err;
      logic [7:0]  lc, tc, a, b;
      logic [31:0] cval, exp_c;
   } vec_t;

   typedef struct {
      logic [31:0] val;
      int          due;
   } sb_t;

   vec_t vt[25];
   sb_t  sbq[$];

   function automatic vec_t mk(input int lv, input int tv, input int lc, input int tc,
                               input int typ, input int a, input int b, input int st,
                               input int exp_c, input int exp_err,
                               input int cv, input int cval, input int c_exp);
      vec_t m;
      m.lv = lv[0];  m.tv = tv[0];  m.lc = lc[7:0];  m.tc = tc[7:0];
      m.typ = typ[0]; m.a = a[7:0]; m.b = b[7:0];    m.st = st[0];
      m.exp_c = exp_c; m.exp_err = exp_err[0];
      m.cv = cv[0];  m.cval = cval;  m.c_exp = c_exp[0];
      return m;
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      t_valid = 0; t_cnt = 0; t_data = 0; t_st = 0; t_cv = 0; t_c = 0;
      l_valid = 0; l_cnt = 0; l_type = 0; l_data = 0;
   endtask

   task automatic apply(input vec_t v);
      sb_t e;
      t_valid = v.tv; t_cnt = v.tc; t_data = v.b; t_st = v.st;
      t_cv = v.cv; t_c = v.cval;
      l_valid = v.lv; l_cnt = v.lc; l_type = v.typ; l_data = v.a;
      if (v.st) begin
         e.val = v.exp_c; e.due = cyc + 1; sbq.push_back(e);
      end
      if (v.cv && v.c_exp) begin
         e.val = v.cval; e.due = cyc + 2; sbq.push_back(e);
      end
      tick();
      chk("forward", {bd_valid, bd_cnt, bd_data, rd_valid, rd_cnt, rd_type, rd_data, b_st},
          {v.tv, v.tc, v.b, v.lv, v.lc, v.typ, v.a, v.st});
      chk("err", err, v.exp_err);
   endtask

   task automatic sat_drive(input int lv, input int tv, input int cnt, input int typ,
                            input int a, input int b, input int st);
      s_lv = lv[0]; s_tv = tv[0]; s_cnt = cnt[7:0]; s_type = typ[0];
      s_a = a[7:0]; s_b = b[7:0]; s_st = st[0];
   endtask

   // Drain monitor: every bot_c beat must match the queue head on its due cycle.
   always @(negedge clk) begin
      sb_t e;
      if (rst_n) begin
         if (sbq.size() > 0 && sbq[0].due < cyc) begin
            e = sbq.pop_front();
            tests++; fails++;
            $display("FAIL drain_missing: got none expected %0h due %0d (cycle %0d)", e.val, e.due, cyc);
         end
         if (bc_valid) begin
            tests++;
            if (sbq.size() == 0) begin
               fails++;
               $display("FAIL drain_unexpected: got %0h expected nothing (cycle %0d)", bc, cyc);
            end else begin
               e = sbq.pop_front();
               if (bc !== e.val || cyc != e.due) begin
                  fails++;
                  $display("FAIL drain: got %0h at %0d expected %0h at %0d", bc, cyc, e.val, e.due);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cexp[6];
      logic cvexp[6];

      // lv tv lc tc typ a b st exp_c err cv cval c_exp
      vt[0]  = mk(1,1,0,0,1,   3,  -4,0,     0,0,0,   0,0);
      vt[1]  = mk(1,1,1,1,0,   5,   6,0,     0,0,0,   0,0);
      vt[2]  = mk(0,0,0,0,0,   0,   0,1,    18,0,0,   0,0);
      vt[3]  = mk(1,1,4,4,1,-128,-128,1, 16384,0,0,   0,0);
      vt[4]  = mk(1,1,5,5,0,-128, 127,0,     0,0,0,   0,0);
      vt[5]  = mk(1,0,6,6,0, 100, 100,0,     0,0,0,   0,0);
      vt[6]  = mk(0,1,6,6,0, 100, 100,0,     0,0,0,   0,0);
      vt[7]  = mk(0,0,0,0,0,   0,   0,1,-16256,0,0,   0,0);
      vt[8]  = mk(0,0,0,0,0,   0,   0,1,     0,0,0,   0,0);
      vt[9]  = mk(1,1,5,5,1,   7,   7,0,     0,0,0,   0,0);
      vt[10] = mk(1,1,6,6,0, 127, 127,0,     0,0,0,   0,0);
      vt[11] = mk(1,1,9,9,1,  -1,   1,0,     0,0,0,   0,0);
      vt[12] = mk(0,0,0,0,0,   0,   0,1,    -1,0,0,   0,0);
      vt[13] = mk(1,1,2,3,0,   9,   9,0,     0,1,0,   0,0);
      vt[14] = mk(0,0,0,0,0,   0,   0,1,     0,1,0,   0,0);
      vt[15] = mk(1,1,7,7,0,   1,   1,1,     1,1,0,   0,0);
      // after mid-drain reset
      vt[16] = mk(0,0,0,0,0,   0,   0,1,     0,0,0,   0,0);
      vt[17] = mk(0,0,0,0,0,   0,   0,0,     0,0,1,1234,1);
      vt[18] = mk(1,1,0,0,1,   2,   3,0,     0,0,1, 999,0);
      vt[19] = mk(0,0,0,0,0,   0,   0,1,     6,1,0,   0,0);
      vt[20] = mk(0,0,0,0,0,   0,   0,0,     0,1,0,   0,0);
      vt[21] = mk(0,0,0,0,0,   0,   0,0,     0,1,1,  77,1);
      vt[22] = mk(1,1,3,3,1,  -3,   5,0,     0,1,0,   0,0);
      vt[23] = mk(0,0,0,0,0,   0,   0,1,   -15,1,0,   0,0);
      vt[24] = mk(0,0,0,0,0,   0,   0,0,     0,1,0,   0,0);

      rst_n = 0;
      drive_idle();
      sat_drive(0,0,0,0,0,0,0);
      col_tv = 0; col_tc = 0; col_td = 0; col_st = 0;
      for (int i = 0; i < 3; i++) begin
         cl_v[i] = 0; cl_c[i] = 0; cl_t[i] = 0; cl_d[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs",
          {bd_valid, bd_cnt, bd_data, rd_valid, rd_cnt, rd_type, rd_data, b_st, bc_valid, bc, err}, 0);
      rst_n = 1;

      for (int i = 0; i < 16; i++) apply(vt[i]);
      drive_idle();
      repeat (2) tick();

      // Reset while an inject is on the output and an upstream beat is in flight.
      l_valid = 1; t_valid = 1; l_cnt = 0; t_cnt = 0; l_type = 1; l_data = 4; t_data = 4;
      tick();
      drive_idle();
      t_st = 1; t_cv = 1; t_c = 555;
      tick();
      chk("inject_pre_reset", {bc_valid, bc}, {1'b1, 32'd16});
      drive_idle();
      #1 rst_n = 0;
      #1;
      chk("reset_async",
          {bd_valid, bd_cnt, bd_data, rd_valid, rd_cnt, rd_type, rd_data, b_st, bc_valid, bc, err}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      for (int i = 16; i < 25; i++) apply(vt[i]);
      drive_idle();
      repeat (4) tick();
      chk("scoreboard_drained", sbq.size(), 0);

      // 16-bit accumulator: positive and negative overflow, saturating vs wrapping.
      sat_drive(1,1,0,1,127,127,0); tick();
      sat_drive(1,1,1,0,127,127,0); tick();
      sat_drive(1,1,2,0,127,127,0); tick();
      sat_drive(0,0,0,0,0,0,1);     tick();
      chk("sat_pos",  {sa_cv[0], sa_c[0]}, {1'b1, 16'h7FFF});
      chk("wrap_pos", {sa_cv[1], sa_c[1]}, {1'b1, 16'hBD03});
      sat_drive(1,1,0,1,-128,127,0); tick();
      sat_drive(1,1,1,0,-128,127,0); tick();
      sat_drive(1,1,2,0,-128,127,0); tick();
      sat_drive(0,0,0,0,0,0,1);      tick();
      chk("sat_neg",  {sa_cv[0], sa_c[0]}, {1'b1, 16'h8000});
      chk("wrap_neg", {sa_cv[1], sa_c[1]}, {1'b1, 16'h4180});
      sat_drive(0,0,0,0,0,0,0);
      tick();
      chk("sat_err", {sa_err[0], sa_err[1]}, 2'b00);

      // Column: load 10/20/30 top to bottom, then drain through the bottom PE.
      col_tv = 1; col_tc = 0; col_td = 1;
      cl_v[0] = 1; cl_c[0] = 0; cl_t[0] = 1; cl_d[0] = 10;
      tick();
      col_tv = 0; cl_v[0] = 0;
      cl_v[1] = 1; cl_c[1] = 0; cl_t[1] = 1; cl_d[1] = 20;
      tick();
      cl_v[1] = 0;
      cl_v[2] = 1; cl_c[2] = 0; cl_t[2] = 1; cl_d[2] = 30;
      tick();
      cl_v[2] = 0;
      col_st = 1;
      cexp  = '{0, 0, 30, 20, 10, 0};
      cvexp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 6; k++) begin
         tick();
         col_st = 0;
         chk("column_drain", {c_bcv[2], (c_bcv[2] ? c_bc[2] : 32'd0)},
             {cvexp[k], cexp[k][31:0]});
      end
      chk("column_err", {c_err[0], c_err[1], c_err[2]}, 3'b000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pe_os.md
PE_OS -- requirements
Module: pe_os

Interface
REQ-001 Parameter DATA_W, default 8, operand width (A from left, B from top).
REQ-002 Parameter ACC_W, default 32, accumulator and drain width; SHALL be at least 2*DATA_W.
REQ-003 Parameter CNT_W, default 8, k-index tag width.
REQ-004 Parameter SIGNED, default 1; 1 = two's-complement operands, 0 = unsigned.
REQ-005 Parameter SAT, default 0; 0 = accumulator wraps mod 2^ACC_W, 1 = saturates.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 top_data_valid_i / top_data_cnt_i / top_data_i  in  1 / CNT_W / DATA_W  B operand beat, its k tag and data.
REQ-009 top_storec_valid_i  in  1  single-cycle drain command.
REQ-010 top_c_valid_i / top_c_i  in  1 / ACC_W  drain beats from the PE above.
REQ-011 left_data_valid_i / left_data_cnt_i / left_data_type_i / left_data_i  in  1 / CNT_W / 1 / DATA_W  A operand beat; type 1 = first k of a tile.
REQ-012 bot_data_valid_o / bot_data_cnt_o / bot_data_o  out  1 / CNT_W / DATA_W  B beat forwarded down.
REQ-013 right_data_valid_o / right_data_cnt_o / right_data_type_o / right_data_o  out  1 / CNT_W / 1 / DATA_W  A beat forwarded right.
REQ-014 bot_storec_valid_o  out  1  drain command forwarded down.
REQ-015 bot_c_valid_o / bot_c_o  out  1 / ACC_W  drain beats down.
REQ-016 err_o  out  1  sticky protocol-error flag.

Function
REQ-017 Forwarding: each top/left field SHALL appear on the matching bot/right output exactly 1 cycle later, unmodified, independent of MAC activity.
REQ-018 MAC fires when left_data_valid_i and top_data_valid_i are both 1 and left_data_cnt_i == top_data_cnt_i.
REQ-019 Product: full 2*DATA_W product, sign- or zero-extended per SIGNED, then extended to ACC_W.
REQ-020 On a fire with left_data_type_i=1, acc <= product; with type 0, acc <= acc + product.
REQ-021 SAT=0: the sum wraps mod 2^ACC_W. SAT=1: the sum clamps to the max/min representable value per SIGNED.
REQ-022 Both valids with unequal cnt: no accumulate, err_o set. Exactly one valid: no accumulate, no error.
REQ-023 Drain inject: when top_storec_valid_i=1 at cycle t, the accumulator value after any same-cycle MAC drives bot_c_o with bot_c_valid_o=1 at t+1; acc clears to 0 at t+1.
REQ-024 Drain forward: top_c beats pass through a 2-stage register path, so a beat at cycle u appears on bot_c_o at u+2.
REQ-025 bot_storec_valid_o SHALL equal top_storec_valid_i delayed 1 cycle. A column then drains bottom PE first, upstream results following back-to-back.
REQ-026 Collision: a forwarded beat due on bot_c_o in the same cycle as an inject means top_c_valid_i=1 one cycle before storec. The inject wins, the forwarded beat is dropped, and err_o is set.
REQ-027 A second top_storec_valid_i while forwarded beats are in flight is legal and follows REQ-023/REQ-024.
REQ-028 err_o stays 1 until reset.
REQ-029 Latency summary: operand forward 1, MAC to acc 1, inject 1, drain forward 2.

Reset
REQ-030 While rst_n=0, every output SHALL be 0, acc = 0, both drain stages empty, err_o = 0.
REQ-031 Reset mid-MAC or mid-drain discards all accumulator and in-flight beats; after release the block is idle and nothing partial is emitted.

Verification
REQ-032 DATA_W=8, SIGNED=1: k0 type1 A=3 B=-4, then k1 A=5 B=6, then storec -> bot_c_o=18 one cycle after storec; acc then 0.
REQ-033 SAT=1, ACC_W=16, SIGNED=1: repeat 127*127 accumulation 3 times -> bot_c_o=32767. Same with SAT=0 -> bot_c_o=48387-65536=-17149.
REQ-034 Both valid with left cnt=2, top cnt=3 -> no accumulate, err_o=1 next cycle and stays 1; bot/right still forward cnt 3/2.
REQ-035 3-PE column, acc {10,20,30} top to bottom, storec into top PE at t -> bottom bot_c_o = 30,20,10 at t+3,t+4,t+5 with valid contiguous.
REQ-036 Assert rst_n=0 during a drain -> all outputs 0 immediately; after release a storec emits 0.
REQ-037 top_c_valid_i=1 at t-1 and storec at t -> bot_c_o = own acc at t+1, err_o=1.
